// File: rtl/crossbar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crossbar_pkg
// Description : Constants and types shared by crossbar4x4, inputQueue and the
//               per-port egress buffers.
// Revision    : 1.0 - initial release
// ============================================================================
package crossbar_pkg;

    localparam int FLIT_W     = 320;   // flit payload bits
    localparam int PORT_DEPTH = 64;    // default per-port buffer depth
    localparam int DROP_CNT_W = 16;    // width of the saturating drop counter

    typedef logic [FLIT_W-1:0] flit_t;

endpackage : crossbar_pkg
`default_nettype wire

// File: rtl/egress_mem.sv
`default_nettype none
// ============================================================================
// Module      : egress_mem
// Description : depth x width register array, one synchronous write port and
//               one asynchronous (combinational) read port. Not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module egress_mem
    import crossbar_pkg::*;
#(
    parameter int width = FLIT_W,
    parameter int depth = PORT_DEPTH
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(depth)-1:0] wr_idx_i,
    input  logic [width-1:0]         wr_data_i,
    input  logic [$clog2(depth)-1:0] rd_idx_i,
    output logic [width-1:0]         rd_data_o
);

    logic [width-1:0] mem_q [depth];

    // Storage write: contents carry no reset, stale entries are never read
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule : egress_mem
`default_nettype wire

// File: rtl/egress_buffer.sv
`default_nettype none
// ============================================================================
// Module      : egress_buffer
// Description : Per-output-port egress FIFO downstream of a crossbar port.
//               Captures flits with no backpressure (drops and counts when
//               full), presents a show-ahead valid/ready output and an
//               almost_full early-warning flag.
// Revision    : 1.0 - initial release
// ============================================================================
module egress_buffer
    import crossbar_pkg::*;
#(
    parameter int width        = FLIT_W,
    parameter int depth        = PORT_DEPTH,
    parameter int afull_thresh = 60
) (
    input  logic                      clk,
    input  logic                      rst,          // async, active-low
    input  logic                      in_valid,
    input  logic [width-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [width-1:0]          out_data,
    output logic [$clog2(depth):0]    count,
    output logic                      full,
    output logic                      almost_full,
    output logic [DROP_CNT_W-1:0]     drop_cnt,
    input  logic                      drop_clr
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]         c_depth    = PW'(depth);
    localparam logic [PW-1:0]         c_afull    = PW'(afull_thresh);
    localparam logic [DROP_CNT_W-1:0] c_drop_max = '1;

    // Pointers carry a wrap bit in the MSB; index is the low AW bits
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q,  count_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic empty;
    logic push;
    logic pop;
    logic drop;

    // Status derived only from registered state, so reset clears it at once
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign out_valid   = !empty;
    assign full        = (count_q == c_depth);
    assign almost_full = (count_q >= c_afull);
    assign count       = count_q;
    assign drop_cnt    = drop_cnt_q;

    // A pop frees a slot in the same cycle, so a full buffer can still accept
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    egress_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push),
        .wr_idx_i  (wr_ptr_q[AW-1:0]),
        .wr_data_i (in_data),
        .rd_idx_i  (rd_ptr_q[AW-1:0]),
        .rd_data_o (out_data)
    );

    // Next-state for pointers, occupancy and the saturating drop counter
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        // Clear wins over a coincident drop
        if (drop_clr) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != c_drop_max)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule : egress_buffer
`default_nettype wire

// File: tb/tb_egress_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_egress_buffer
// Description : Directed self-checking bench for egress_buffer, depth 8 and
//               almost_full threshold 6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_egress_buffer;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int TH = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [3:0]    count;
    logic          full;
    logic          almost_full;
    logic [15:0]   drop_cnt;
    logic          drop_clr = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    egress_buffer #(
        .width        (W),
        .depth        (D),
        .afull_thresh (TH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .full        (full),
        .almost_full (almost_full),
        .drop_cnt    (drop_cnt),
        .drop_clr    (drop_clr)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [W-1:0] drain_exp [8];
    int           pop_idx;
    int           msb_toggles;
    logic         prev_msb;

    initial begin
        drain_exp[0] = 16'h2; drain_exp[1] = 16'h3; drain_exp[2] = 16'h4;
        drain_exp[3] = 16'h5; drain_exp[4] = 16'h6; drain_exp[5] = 16'h7;
        drain_exp[6] = 16'h8; drain_exp[7] = 16'hA;

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_full", 32'(full), 0);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_drop", 32'(drop_cnt), 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Fill 0x1..0x8 with out_ready low
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            tick();
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), (i >= TH) ? 32'd1 : 32'd0);
            check("fill_full", 32'(full), (i == D) ? 32'd1 : 32'd0);
        end
        check("fill_head", 32'(out_data), 32'h1);

        // Overflow: three drops while full
        for (int i = 0; i < 3; i++) begin
            in_data = W'(16'h31 + i);
            tick();
        end
        check("ovf_drop3", 32'(drop_cnt), 3);
        check("ovf_count", 32'(count), 8);
        check("ovf_head", 32'(out_data), 32'h1);
        // Clear coincident with a fourth drop
        drop_clr = 1'b1;
        in_data  = 16'h34;
        tick();
        drop_clr = 1'b0;
        check("ovf_clr", 32'(drop_cnt), 0);

        // Full with concurrent push and pop
        in_data   = 16'hA;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("fpp_count", 32'(count), 8);
        check("fpp_drop", 32'(drop_cnt), 0);
        check("fpp_full", 32'(full), 1);

        // Drain: 0x2..0x8 then 0xA
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", 32'(out_valid), 1);
            check("drain_data", 32'(out_data), 32'(drain_exp[i]));
            tick();
        end
        check("drain_empty", 32'(out_valid), 0);
        check("drain_count", 32'(count), 0);

        // Latency and hold; push into empty with out_ready high
        in_valid = 1'b1;
        in_data  = 16'h55;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("lat_valid", 32'(out_valid), 1);
        check("lat_data", 32'(out_data), 32'h55);
        check("lat_count", 32'(count), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_data", 32'(out_data), 32'h55);
        end
        out_ready = 1'b1;
        tick();
        check("hold_pop", 32'(out_valid), 0);

        // Wrap-around: push 0x10..0x23, pops lag by one cycle
        pop_idx     = 0;
        msb_toggles = 0;
        prev_msb    = dut.wr_ptr_q[3];
        for (int i = 0; i <= 20; i++) begin
            in_valid  = (i < 20);
            in_data   = W'(16'h10 + i);
            out_ready = (i > 0);
            if (i > 0) begin
                check("wrap_valid", 32'(out_valid), 1);
                check("wrap_data", 32'(out_data), 32'(16'h10 + pop_idx));
                pop_idx++;
            end
            tick();
            check("wrap_count_le1", 32'(count <= 4'd1), 1);
            if (dut.wr_ptr_q[3] != prev_msb) msb_toggles++;
            prev_msb = dut.wr_ptr_q[3];
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("wrap_pops", 32'(pop_idx), 20);
        check("wrap_msb_toggles", 32'(msb_toggles >= 2), 1);
        check("wrap_empty", 32'(out_valid), 0);

        // Build count=5, drop_cnt=2, then asynchronous reset
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = W'(16'h60 + i);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        out_ready = 1'b0;
        check("pre_rst_count", 32'(count), 5);
        check("pre_rst_drop", 32'(drop_cnt), 2);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_full", 32'(full), 0);
        check("arst_afull", 32'(almost_full), 0);
        check("arst_drop", 32'(drop_cnt), 0);
        tick();
        rst = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7;
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 1);
        check("post_rst_data", 32'(out_data), 32'h7);
        check("post_rst_count", 32'(count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_egress_buffer
`default_nettype wire
